// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable prescaled countdown timer, one-shot or periodic, Moore FSM
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             trigger,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, RUN, PAUSED, FIRE, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [WIDTH-1:0] count_r, count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             mode, mode_nxt;
  logic             wrap, expire;

  assign wrap   = (presc == PMAX);
  assign expire = wrap && (count_r == WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Leaving PAUSED on the edge that sees pause low counts that edge, so each
  // paused cycle costs exactly one cycle of latency.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = (load_val == '0) ? FIRE : RUN;
    end else begin
      case (state)
        RUN:     if (pause) state_nxt = PAUSED;
                 else if (expire) state_nxt = FIRE;
        PAUSED:  if (!pause) state_nxt = expire ? FIRE : RUN;
        FIRE:    if (mode) state_nxt = (reload == '0) ? FIRE : RUN;
                 else state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy    = (state == RUN) || (state == PAUSED) || (state == FIRE);
    trigger = (state == FIRE);
    done    = (state == DONE);
  end

  always_comb begin
    presc_nxt  = presc;
    count_nxt  = count_r;
    reload_nxt = reload;
    mode_nxt   = mode;
    if (abort) begin
      presc_nxt = '0;
      count_nxt = '0;
    end else if (start) begin
      reload_nxt = load_val;
      mode_nxt   = periodic;
      presc_nxt  = '0;
      count_nxt  = load_val;
    end else begin
      case (state)
        RUN, PAUSED: begin
          if (!pause) begin
            presc_nxt = wrap ? '0 : presc + PW'(1);
            if (wrap) count_nxt = count_r - WIDTH'(1);
          end
        end
        FIRE: begin
          presc_nxt = '0;
          count_nxt = mode ? reload : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      count_r <= '0;
      reload  <= '0;
      mode    <= 1'b0;
    end else begin
      presc   <= presc_nxt;
      count_r <= count_nxt;
      reload  <= reload_nxt;
      mode    <= mode_nxt;
    end
  end

  assign count = count_r;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer (PRESCALE=1 and PRESCALE=3)
module tb_countdown_timer;

  typedef struct {
    int cyc;
    int dut;
    int cnt;
    bit busy;
    bit trig;
    bit done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] load_val;
  logic       start, periodic, pause, abort;
  logic [7:0] c1, c3;
  logic       b1, t1, d1, b3, t3, d3;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t e_mon;

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start), .periodic(periodic),
    .pause(pause), .abort(abort), .count(c1), .busy(b1), .trigger(t1), .done(d1)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(3)) u3 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start), .periodic(periodic),
    .pause(pause), .abort(abort), .count(c3), .busy(b3), .trigger(t3), .done(d3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      e_mon = sb[i];
      if (e_mon.cyc <= cyc) begin
        logic [7:0] ac;
        logic       ab, at, ad;
        ac = e_mon.dut ? c3 : c1;
        ab = e_mon.dut ? b3 : b1;
        at = e_mon.dut ? t3 : t1;
        ad = e_mon.dut ? d3 : d1;
        checks += 4;
        if (e_mon.cyc < cyc) begin
          fails++;
          $display("FAIL stale_entry cyc=%0d dut=%0d actual=unchecked required=checked", e_mon.cyc, e_mon.dut);
        end else begin
          if (int'(ac) != e_mon.cnt) begin
            fails++;
            $display("FAIL count cyc=%0d dut=%0d actual=%0d required=%0d", cyc, e_mon.dut, ac, e_mon.cnt);
          end
          if (ab != e_mon.busy) begin
            fails++;
            $display("FAIL busy cyc=%0d dut=%0d actual=%0b required=%0b", cyc, e_mon.dut, ab, e_mon.busy);
          end
          if (at != e_mon.trig) begin
            fails++;
            $display("FAIL trigger cyc=%0d dut=%0d actual=%0b required=%0b", cyc, e_mon.dut, at, e_mon.trig);
          end
          if (ad != e_mon.done) begin
            fails++;
            $display("FAIL done cyc=%0d dut=%0d actual=%0b required=%0b", cyc, e_mon.dut, ad, e_mon.done);
          end
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int d, input int cnt, input bit b, input bit t, input bit dn);
    exp_t e;
    e.cyc = c; e.dut = d; e.cnt = cnt; e.busy = b; e.trig = t; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input int val, input bit per, output int e);
    load_val = 8'(val);
    periodic = per;
    start    = 1'b1;
    e        = cyc + 1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, e2, ph;
    rst = 1'b0; load_val = '0; start = 0; periodic = 0; pause = 0; abort = 0;
    for (int c = 1; c <= 3; c++) begin
      push(c, 0, 0, 0, 0, 0);
      push(c, 1, 0, 0, 0, 0);
    end
    steps(3);
    rst = 1'b1;
    step();

    // one-shot, load 5
    do_start(5, 0, e);
    for (int t = 0; t <= 5; t++) push(e + t, 0, 5 - t, 1, t == 5, 0);
    push(e + 6, 0, 0, 0, 0, 1);
    push(e + 7, 0, 0, 0, 0, 1);
    steps(8);

    // periodic, PRESCALE=3, load 2: period 7
    do_start(2, 1, e);
    for (int t = 0; t <= 20; t++) begin
      ph = t % 7;
      if (ph == 6) push(e + t, 1, 0, 1, 1, 0);
      else         push(e + t, 1, 2 - ph / 3, 1, 0, 0);
    end
    steps(21);
    abort = 1'b1; step(); abort = 1'b0;

    // pause for 4 cycles at count 2: trigger moves from E+4 to E+8
    do_start(4, 0, e);
    push(e, 0, 4, 1, 0, 0);
    push(e + 1, 0, 3, 1, 0, 0);
    for (int t = 2; t <= 6; t++) push(e + t, 0, 2, 1, 0, 0);
    push(e + 7, 0, 1, 1, 0, 0);
    push(e + 8, 0, 0, 1, 1, 0);
    push(e + 9, 0, 0, 0, 0, 1);
    steps(2);
    pause = 1'b1;
    steps(4);
    pause = 1'b0;
    steps(4);

    // restart mid-count, then abort beats start
    do_start(6, 0, e);
    push(e + 1, 0, 5, 1, 0, 0);
    push(e + 2, 0, 4, 1, 0, 0);
    steps(2);
    do_start(9, 0, e2);
    push(e2, 0, 9, 1, 0, 0);
    push(e2 + 1, 0, 8, 1, 0, 0);
    step();
    abort = 1'b1; start = 1'b1; load_val = 8'd7;
    step();
    abort = 1'b0; start = 1'b0;
    push(e2 + 2, 0, 0, 0, 0, 0);
    push(e2 + 3, 0, 0, 0, 0, 0);
    steps(2);

    // load 0 one-shot
    do_start(0, 0, e);
    push(e, 0, 0, 1, 1, 0);
    push(e + 1, 0, 0, 0, 0, 1);
    steps(2);

    // load 0 periodic holds trigger until abort
    do_start(0, 1, e);
    for (int t = 0; t <= 4; t++) push(e + t, 0, 0, 1, 1, 0);
    steps(4);
    abort = 1'b1; step(); abort = 1'b0;
    push(e + 5, 0, 0, 0, 0, 0);
    step();

    // load 255, no wrap
    do_start(255, 0, e);
    push(e, 0, 255, 1, 0, 0);
    push(e + 1, 0, 254, 1, 0, 0);
    push(e + 253, 0, 2, 1, 0, 0);
    push(e + 254, 0, 1, 1, 0, 0);
    push(e + 255, 0, 0, 1, 1, 0);
    push(e + 256, 0, 0, 0, 0, 1);
    steps(258);

    // asynchronous reset between edges while count is 3
    do_start(5, 0, e);
    push(e + 1, 0, 4, 1, 0, 0);
    steps(2);
    rst = 1'b0;
    push(e + 2, 0, 0, 0, 0, 0);
    push(e + 2, 1, 0, 0, 0, 0);
    push(e + 3, 0, 0, 0, 0, 0);
    steps(2);
    rst = 1'b1;
    steps(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
